// File: rtl/ghost_pkg.sv
// Shared ghost-mode types: sequencer states, mode encodings and the scatter/chase schedule table.
package ghost_pkg;

  typedef enum logic [1:0] {StIdle, StScatter, StChase, StFright} state_e;

  // Mirrors the game_mode encodings in constants.vh
  localparam logic [1:0] CHASE_MODE      = 2'd0;
  localparam logic [1:0] SCATTER_MODE    = 2'd1;
  localparam logic [1:0] FRIGHTENED_MODE = 2'd2;

  // Frame length of a schedule phase; phase 7 never expires and returns 0.
  function automatic int unsigned phase_len(logic [2:0] idx, int unsigned scat_long,
                                            int unsigned scat_short, int unsigned chase);
    case (idx)
      3'd0, 3'd2:       phase_len = scat_long;
      3'd1, 3'd3, 3'd5: phase_len = chase;
      3'd4, 3'd6:       phase_len = scat_short;
      default:          phase_len = 0;
    endcase
  endfunction

  function automatic logic [1:0] mode_of(state_e s);
    case (s)
      StChase:  mode_of = CHASE_MODE;
      StFright: mode_of = FRIGHTENED_MODE;
      default:  mode_of = SCATTER_MODE;
    endcase
  endfunction

endpackage

// File: rtl/ghost_mode_seq_if.sv
// game_mode bus between the mode sequencer (master) and the ghost movers/drawers (slave).
interface ghost_mode_seq_if;
  logic       frame_tick;
  logic       level_start;
  logic       pellet_eaten;
  logic       pause;
  logic       dev_mode;
  logic [1:0] game_mode;
  logic       mode_changed;
  logic       fright_blink;
  logic [2:0] phase_idx;

  modport master (
    input  frame_tick, level_start, pellet_eaten, pause, dev_mode,
    output game_mode, mode_changed, fright_blink, phase_idx
  );

  modport slave (
    output frame_tick, level_start, pellet_eaten, pause, dev_mode,
    input  game_mode, mode_changed, fright_blink, phase_idx
  );
endinterface

// File: rtl/frame_down_counter.sv
// Loadable, tick-enabled down counter that stops at zero; terminal flags the last count.
module frame_down_counter #(
  parameter int unsigned Width = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             tick,
  output logic [Width-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign terminal = (count == Width'(1));

endmodule

// File: rtl/ghost_mode_seq.sv
// Global ghost mode sequencer: scatter/chase schedule on frame ticks, frightened override on
// power pellets, reversal pulse and end-of-fright blink.
module ghost_mode_seq
  import ghost_pkg::*;
#(
  parameter int unsigned FRAME_RATE      = 60,
  parameter int unsigned SCATTER_LONG_S  = 7,
  parameter int unsigned SCATTER_SHORT_S = 5,
  parameter int unsigned CHASE_S         = 20,
  parameter int unsigned FRIGHT_S        = 6,
  parameter int unsigned BLINK_S         = 2
) (
  input logic               clk,
  input logic               reset,
  ghost_mode_seq_if.master  bus
);

  localparam int unsigned ScatLong  = SCATTER_LONG_S * FRAME_RATE;
  localparam int unsigned ScatShort = SCATTER_SHORT_S * FRAME_RATE;
  localparam int unsigned ChaseLen  = CHASE_S * FRAME_RATE;
  localparam int unsigned FrightLen = FRIGHT_S * FRAME_RATE;
  localparam int unsigned BlinkLen  = BLINK_S * FRAME_RATE;
  localparam int unsigned MaxScat   = (ScatLong > ScatShort) ? ScatLong : ScatShort;
  localparam int unsigned MaxPhase  = (MaxScat > ChaseLen) ? MaxScat : ChaseLen;
  localparam int unsigned PhaseW    = $clog2(MaxPhase + 1);
  localparam int unsigned FrightW   = $clog2(FrightLen + 1);

  state_e              state_q, saved_q;
  logic [1:0]          mode_q;
  logic [2:0]          phase_idx_q;
  logic [PhaseW-1:0]   phase_cnt_q;
  logic                mode_changed_q, fright_blink_q;
  logic [FrightW-1:0]  fright_cnt;
  logic                fright_last;

  logic eff_tick, active, phase_expire, fr_load, fr_clear, fr_tick;

  assign eff_tick = bus.frame_tick & ~bus.pause & ~bus.dev_mode;
  assign active   = ~bus.dev_mode;
  assign phase_expire = (phase_idx_q != 3'd7) &&
      (phase_cnt_q == PhaseW'(phase_len(phase_idx_q, ScatLong, ScatShort, ChaseLen) - 1));

  // level_start outranks pellets, which outrank the fright countdown
  assign fr_clear = active & bus.level_start;
  assign fr_load  = active & ~bus.level_start & bus.pellet_eaten & (state_q != StIdle);
  assign fr_tick  = eff_tick & ~bus.level_start & ~bus.pellet_eaten & (state_q == StFright);

  frame_down_counter #(
    .Width (FrightW)
  ) u_fright_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (fr_clear),
    .load     (fr_load),
    .load_val (FrightW'(FrightLen)),
    .tick     (fr_tick),
    .count    (fright_cnt),
    .terminal (fright_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      saved_q        <= StScatter;
      mode_q         <= SCATTER_MODE;
      phase_idx_q    <= 3'd0;
      phase_cnt_q    <= '0;
      mode_changed_q <= 1'b0;
      fright_blink_q <= 1'b0;
    end else if (!active) begin
      mode_changed_q <= 1'b0;
    end else begin
      mode_changed_q <= 1'b0;
      if (bus.level_start) begin
        state_q        <= StScatter;
        mode_q         <= SCATTER_MODE;
        phase_idx_q    <= 3'd0;
        phase_cnt_q    <= '0;
        fright_blink_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StScatter, StChase: begin
            if (bus.pellet_eaten) begin
              saved_q        <= state_q;
              state_q        <= StFright;
              mode_q         <= FRIGHTENED_MODE;
              mode_changed_q <= 1'b1;
              fright_blink_q <= 1'b0;
            end else if (eff_tick) begin
              if (phase_expire) begin
                phase_idx_q    <= phase_idx_q + 3'd1;
                phase_cnt_q    <= '0;
                state_q        <= (state_q == StScatter) ? StChase : StScatter;
                mode_q         <= (state_q == StScatter) ? CHASE_MODE : SCATTER_MODE;
                mode_changed_q <= 1'b1;
              end else if (phase_cnt_q != '1) begin
                phase_cnt_q <= phase_cnt_q + 1'b1;
              end
            end
          end
          StFright: begin
            if (bus.pellet_eaten) begin
              mode_changed_q <= 1'b1;
              fright_blink_q <= 1'b0;
            end else if (eff_tick) begin
              if (fright_last) begin
                state_q        <= saved_q;
                mode_q         <= mode_of(saved_q);
                fright_blink_q <= 1'b0;
              end else begin
                // Blink follows the post-decrement count
                fright_blink_q <= (fright_cnt <= FrightW'(BlinkLen + 1));
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.game_mode    = bus.dev_mode ? CHASE_MODE : mode_q;
  assign bus.mode_changed = mode_changed_q & ~bus.dev_mode;
  assign bus.fright_blink = fright_blink_q;
  assign bus.phase_idx    = phase_idx_q;

endmodule

// File: tb/tb_ghost_mode_seq.sv
// Directed self-checking bench for ghost_mode_seq at default parameters.
module tb_ghost_mode_seq;
  import ghost_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulses = 0;

  ghost_mode_seq_if bus();

  ghost_mode_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs sampled at the edge, outputs observed 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.mode_changed === 1'b1) pulses++;
  endtask

  task automatic ticks(input int n);
    bus.frame_tick = 1'b1;
    repeat (n) step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_pellet();
    bus.pellet_eaten = 1'b1;
    step();
    bus.pellet_eaten = 1'b0;
  endtask

  task automatic pulse_level();
    bus.level_start = 1'b1;
    step();
    bus.level_start = 1'b0;
  endtask

  task automatic expect_state(input string tag, input logic [1:0] mode, input logic [2:0] idx,
                              input logic blink);
    check_eq({tag, ".mode"},  32'(bus.game_mode),    32'(mode));
    check_eq({tag, ".phase"}, 32'(bus.phase_idx),    32'(idx));
    check_eq({tag, ".blink"}, 32'(bus.fright_blink), 32'(blink));
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.level_start = 1'b0;
    bus.pellet_eaten = 1'b0;
    bus.pause = 1'b0;
    bus.dev_mode = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    expect_state("reset", SCATTER_MODE, 3'd0, 1'b0);
    check_eq("reset.mc", 32'(bus.mode_changed), 32'd0);

    // IDLE ignores ticks and pellets
    pulses = 0;
    ticks(500);
    pulse_pellet();
    expect_state("idle", SCATTER_MODE, 3'd0, 1'b0);
    check_eq("idle.pulses", 32'(pulses), 32'd0);

    pulse_level();
    expect_state("start", SCATTER_MODE, 3'd0, 1'b0);
    check_eq("start.mc", 32'(bus.mode_changed), 32'd0);

    ticks(419);
    expect_state("scat419", SCATTER_MODE, 3'd0, 1'b0);
    ticks(1);
    expect_state("scat420", CHASE_MODE, 3'd1, 1'b0);
    check_eq("scat420.mc", 32'(bus.mode_changed), 32'd1);
    step();
    check_eq("scat420.mc_off", 32'(bus.mode_changed), 32'd0);

    // Rest of the schedule, then phase 7 holds forever
    pulses = 0;
    ticks(5040 - 420);
    expect_state("sched", CHASE_MODE, 3'd7, 1'b0);
    check_eq("sched.pulses", 32'(pulses), 32'd6);
    pulses = 0;
    ticks(5000);
    expect_state("ph7", CHASE_MODE, 3'd7, 1'b0);
    check_eq("ph7.pulses", 32'(pulses), 32'd0);

    // dev_mode forces CHASE and freezes everything
    pulse_level();
    bus.dev_mode = 1'b1;
    pulses = 0;
    pulse_pellet();
    check_eq("dev.mode", 32'(bus.game_mode), 32'(CHASE_MODE));
    ticks(500);
    bus.dev_mode = 1'b0;
    step();
    expect_state("dev.off", SCATTER_MODE, 3'd0, 1'b0);
    check_eq("dev.pulses", 32'(pulses), 32'd0);
    ticks(419);
    expect_state("dev.scat419", SCATTER_MODE, 3'd0, 1'b0);
    ticks(1);
    expect_state("dev.scat420", CHASE_MODE, 3'd1, 1'b0);

    // Fright from CHASE at phase_cnt=100
    pulse_level();
    ticks(420 + 100);
    pulses = 0;
    pulse_pellet();
    expect_state("fr.enter", FRIGHTENED_MODE, 3'd1, 1'b0);
    check_eq("fr.enter.mc", 32'(bus.mode_changed), 32'd1);
    ticks(239);
    check_eq("fr.239.blink", 32'(bus.fright_blink), 32'd0);
    ticks(1);
    expect_state("fr.240", FRIGHTENED_MODE, 3'd1, 1'b1);
    ticks(119);
    expect_state("fr.359", FRIGHTENED_MODE, 3'd1, 1'b1);
    ticks(1);
    expect_state("fr.360", CHASE_MODE, 3'd1, 1'b0);
    check_eq("fr.pulses", 32'(pulses), 32'd1);
    ticks(1099);
    expect_state("fr.resume1099", CHASE_MODE, 3'd1, 1'b0);
    ticks(1);
    expect_state("fr.resume1100", SCATTER_MODE, 3'd2, 1'b0);
    check_eq("fr.resume.mc", 32'(bus.mode_changed), 32'd1);

    // Pellet on the same clock as a scatter expiry tick
    ticks(419);
    bus.pellet_eaten = 1'b1;
    ticks(1);
    bus.pellet_eaten = 1'b0;
    expect_state("exp.pellet", FRIGHTENED_MODE, 3'd2, 1'b0);
    check_eq("exp.pellet.mc", 32'(bus.mode_changed), 32'd1);
    pulses = 0;
    ticks(360);
    expect_state("exp.back", SCATTER_MODE, 3'd2, 1'b0);
    check_eq("exp.back.pulses", 32'(pulses), 32'd0);
    ticks(1);
    expect_state("exp.next", CHASE_MODE, 3'd3, 1'b0);
    check_eq("exp.next.mc", 32'(bus.mode_changed), 32'd1);

    // Extended fright with a pause window
    pulse_pellet();
    ticks(300);
    check_eq("ext.300.blink", 32'(bus.fright_blink), 32'd1);
    pulse_pellet();
    check_eq("ext.p2.blink", 32'(bus.fright_blink), 32'd0);
    check_eq("ext.p2.mc", 32'(bus.mode_changed), 32'd1);
    ticks(200);
    pulse_pellet();
    ticks(239);
    check_eq("ext.239.blink", 32'(bus.fright_blink), 32'd0);
    bus.pause = 1'b1;
    ticks(50);
    bus.pause = 1'b0;
    expect_state("ext.paused", FRIGHTENED_MODE, 3'd3, 1'b0);
    ticks(1);
    expect_state("ext.240", FRIGHTENED_MODE, 3'd3, 1'b1);
    ticks(119);
    check_eq("ext.359.mode", 32'(bus.game_mode), 32'(FRIGHTENED_MODE));
    ticks(1);
    expect_state("ext.end", CHASE_MODE, 3'd3, 1'b0);

    // level_start together with pellet while frightened
    pulse_pellet();
    ticks(250);
    check_eq("ls.pre.blink", 32'(bus.fright_blink), 32'd1);
    bus.level_start = 1'b1;
    bus.pellet_eaten = 1'b1;
    step();
    bus.level_start = 1'b0;
    bus.pellet_eaten = 1'b0;
    expect_state("ls.both", SCATTER_MODE, 3'd0, 1'b0);
    check_eq("ls.both.mc", 32'(bus.mode_changed), 32'd0);
    ticks(419);
    expect_state("ls.419", SCATTER_MODE, 3'd0, 1'b0);
    ticks(1);
    expect_state("ls.420", CHASE_MODE, 3'd1, 1'b0);

    // Asynchronous reset mid-fright, checked between clock edges
    pulse_pellet();
    ticks(250);
    check_eq("ar.pre.mode", 32'(bus.game_mode), 32'(FRIGHTENED_MODE));
    #2 reset = 1'b1;
    #1;
    expect_state("ar.async", SCATTER_MODE, 3'd0, 1'b0);
    step();
    reset = 1'b0;
    pulses = 0;
    ticks(500);
    expect_state("ar.idle", SCATTER_MODE, 3'd0, 1'b0);
    check_eq("ar.pulses", 32'(pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ghost_mode_seq.md
Name: ghost_mode_seq

Overview:
- Produces the global game_mode (CHASE/SCATTER/FRIGHTENED) consumed by every ghost's target generator. It is the driving end of the game_mode interface.
- Runs the per-level scatter/chase schedule on frame ticks, overrides it with frightened mode on power-pellet events, and resumes the schedule afterwards.
- Emits a reversal pulse for the ghost movers and a blink flag for the ghost drawers.
- Sits in the game-control layer, next to the frame timing and pellet-collision logic.

Parameters:
- FRAME_RATE, 60, frame ticks per second.
- SCATTER_LONG_S, 7, duration in seconds of scatter phases 0 and 2.
- SCATTER_SHORT_S, 5, duration in seconds of scatter phases 4 and 6.
- CHASE_S, 20, duration in seconds of chase phases 1, 3 and 5. Phase 7 is chase, indefinite.
- FRIGHT_S, 6, frightened duration in seconds.
- BLINK_S, 2, length in seconds of the final part of frightened during which fright_blink=1. Must be ≤ FRIGHT_S.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-clk pulse per video frame.
- level_start  in  1  one-clk pulse; restarts the schedule at phase 0.
- pellet_eaten  in  1  one-clk pulse when Pac-Man eats a power pellet.
- pause  in  1  level-sensitive; while 1, frame_tick is ignored.
- dev_mode  in  1  debug; forces CHASE and freezes all timers.
- game_mode  out  2  CHASE_MODE / SCATTER_MODE / FRIGHTENED_MODE encodings from the shared constants.
- mode_changed  out  1  one-clk pulse; ghosts reverse direction.
- fright_blink  out  1  high in the last BLINK_S·FRAME_RATE frames of frightened.
- phase_idx  out  3  current schedule phase, 0..7.

Behaviour:
- States: IDLE, SCATTER, CHASE, FRIGHT. A saved_mode register holds SCATTER or CHASE while in FRIGHT.
- Reset values: state=IDLE, game_mode=SCATTER_MODE, mode_changed=0, fright_blink=0, phase_idx=0, all counters 0.
- All outputs are registered. A qualifying input is reflected one clk after it is sampled.
- "Effective tick" = frame_tick & ~pause & ~dev_mode.
- IDLE: timers stopped, game_mode=SCATTER. On level_start → SCATTER, phase 0, phase_cnt=0; no mode_changed pulse.
- SCATTER/CHASE:
  - Each effective tick increments phase_cnt.
  - When phase_cnt reaches the phase duration minus 1 on an effective tick: phase_idx+1, phase_cnt=0, toggle SCATTER↔CHASE, pulse mode_changed.
  - Phase 7 never expires; phase_cnt saturates.
  - Durations in frames: 420, 1200, 420, 1200, 300, 1200, 300, ∞ at default parameters.
- pellet_eaten in SCATTER/CHASE: saved_mode=current mode, → FRIGHT, fright_cnt=FRIGHT_S·FRAME_RATE, pulse mode_changed. phase_cnt freezes.
- FRIGHT:
  - Each effective tick decrements fright_cnt.
  - fright_blink=1 while fright_cnt ≤ BLINK_S·FRAME_RATE.
  - On an effective tick with fright_cnt=1: fright_cnt=0, fright_blink=0, → saved_mode. No mode_changed pulse. phase_cnt resumes from its frozen value.
- pellet_eaten in FRIGHT: reload fright_cnt to full, fright_blink=0, pulse mode_changed. saved_mode is unchanged.
- pellet_eaten in IDLE: ignored.
- Simultaneous events, by priority:
  - level_start beats everything, including pellet_eaten, in any state: → SCATTER, phase 0, fright cleared.
  - pellet_eaten beats phase expiry on the same clk. The phase counter does not advance, so expiry re-occurs on the first effective tick after FRIGHT ends.
- dev_mode=1: game_mode output forced to CHASE_MODE combinationally after the register. State and counters hold. mode_changed is suppressed.
- Counter widths are $clog2 of the maximum duration plus 1: 11 bits phase_cnt, 9 bits fright_cnt at defaults. Durations are computed as parameter constants; no run-time multipliers.
- Reset asserted mid-frightened returns to IDLE immediately (asynchronous); there is no resume.

Decomposition:
- Shared package ghost_pkg:
  - state enum.
  - Schedule table function phase_len(phase_idx) built from the parameters.
  - Mode encodings mirrored from constants.vh.
- One natural sub-module, frame_down_counter: loadable, tick-enabled down counter with a terminal flag. It is used for fright_cnt; phase_cnt stays inline.

Test Plan:
- reset, then level_start, then 420 effective ticks → game_mode SCATTER→CHASE on the clk after tick 420; mode_changed high for exactly 1 clk; phase_idx=1.
- Full schedule, 5040 ticks → phase_idx=7, CHASE. A further 5000 ticks cause no change and no mode_changed pulse.
- CHASE phase_cnt=100, pellet_eaten → FRIGHTENED with one mode_changed pulse. After 240 ticks fright_blink=1. After 360 ticks CHASE returns with no pulse, and phase_cnt resumes at 100 (expiry after 1100 more ticks).
- pellet_eaten on the same clk as a SCATTER expiry tick → FRIGHTENED and phase_idx unchanged. After 360 ticks SCATTER returns, and the next tick → CHASE with a pulse.
- pellet_eaten at fright tick 300, then at 200 → fright extended; blink drops and re-rises 240 ticks after the last pellet; pause=1 for 50 ticks freezes all counts.
- level_start asserted together with pellet_eaten while in FRIGHT → SCATTER, phase 0, fright_blink=0. Async reset mid-FRIGHT → IDLE and SCATTER immediately, without waiting for a clock edge.
